// File: rtl/mc_ctrl_if.sv
// Control bundle between mc_ctrl and the multi-cycle datapath.
// The controller uses the slave modport; the datapath (or a bench) uses master.
interface mc_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcwr;
  logic       irwr;
  logic [1:0] npcop;
  logic       regwr;
  logic [1:0] regdst;
  logic [1:0] wdsel;
  logic       alusrc;
  logic [1:0] aluop;
  logic [1:0] extop;
  logic       dmwr;
  logic       done;
  logic [2:0] state;

  modport slave (
    input  op, funct, zero,
    output pcwr, irwr, npcop, regwr, regdst, wdsel, alusrc, aluop, extop,
           dmwr, done, state
  );

  modport master (
    output op, funct, zero,
    input  pcwr, irwr, npcop, regwr, regdst, wdsel, alusrc, aluop, extop,
           dmwr, done, state
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset CPU (IF/ID/EXE/MEM/WB/BR).
// Outputs are combinational from state, op, funct and zero.
module mc_ctrl (
  input  logic        clk,
  input  logic        rst,
  mc_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_BR  = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;

  logic w_rtype, w_addu, w_subu, w_jr;
  logic w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal, w_alu_res;

  logic       w_pcwr, w_irwr, w_regwr, w_alusrc, w_dmwr, w_done;
  logic [1:0] w_npcop, w_regdst, w_wdsel, w_aluop, w_extop;
  logic [1:0] w_aluop_x, w_extop_x;
  logic       w_alusrc_x;

  assign w_rtype   = (bus.op == 6'b000000);
  assign w_addu    = w_rtype && (bus.funct == 6'b100001);
  assign w_subu    = w_rtype && (bus.funct == 6'b100011);
  assign w_jr      = w_rtype && (bus.funct == 6'b001000);
  assign w_ori     = (bus.op == 6'b001101);
  assign w_lui     = (bus.op == 6'b001111);
  assign w_lw      = (bus.op == 6'b100011);
  assign w_sw      = (bus.op == 6'b101011);
  assign w_beq     = (bus.op == 6'b000100);
  assign w_j       = (bus.op == 6'b000010);
  assign w_jal     = (bus.op == 6'b000011);
  assign w_alu_res = w_addu | w_subu | w_ori | w_lui;

  // ALU/extender selects for the EXE step; reused where they must be held.
  always_comb begin
    w_aluop_x  = 2'b00;
    w_alusrc_x = 1'b0;
    w_extop_x  = 2'b00;
    if (w_subu) begin
      w_aluop_x = 2'b01;
    end else if (w_ori) begin
      w_aluop_x  = 2'b10;
      w_alusrc_x = 1'b1;
    end else if (w_lui) begin
      w_aluop_x  = 2'b10;
      w_alusrc_x = 1'b1;
      w_extop_x  = 2'b10;
    end else if (w_lw || w_sw) begin
      w_alusrc_x = 1'b1;
      w_extop_x  = 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IF;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = S_IF;
    w_pcwr   = 1'b0;
    w_irwr   = 1'b0;
    w_npcop  = 2'b00;
    w_regwr  = 1'b0;
    w_regdst = 2'b00;
    w_wdsel  = 2'b00;
    w_alusrc = 1'b0;
    w_aluop  = 2'b00;
    w_extop  = 2'b00;
    w_dmwr   = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      S_IF: begin
        w_irwr = 1'b1;
        w_pcwr = 1'b1;
        w_next = S_ID;
      end
      S_ID: begin
        if (w_j) begin
          w_pcwr  = 1'b1;
          w_npcop = 2'b10;
          w_done  = 1'b1;
        end else if (w_jal) begin
          w_pcwr   = 1'b1;
          w_npcop  = 2'b10;
          w_regwr  = 1'b1;
          w_regdst = 2'b10;
          w_wdsel  = 2'b10;
          w_done   = 1'b1;
        end else if (w_jr) begin
          w_pcwr  = 1'b1;
          w_npcop = 2'b11;
          w_done  = 1'b1;
        end else if (w_beq) begin
          w_next = S_BR;
        end else if (w_alu_res || w_lw || w_sw) begin
          w_next = S_EXE;
        end else begin
          w_done = 1'b1;
        end
      end
      S_BR: begin
        // A not-taken branch must not reload PC: npc would add 4 a second time.
        w_aluop = 2'b01;
        w_extop = 2'b01;
        w_npcop = 2'b01;
        w_pcwr  = bus.zero;
        w_done  = 1'b1;
      end
      S_EXE: begin
        w_aluop  = w_aluop_x;
        w_alusrc = w_alusrc_x;
        w_extop  = w_extop_x;
        if (w_lw || w_sw)   w_next = S_MEM;
        else if (w_alu_res) w_next = S_WB;
      end
      S_MEM: begin
        w_alusrc = 1'b1;
        w_extop  = 2'b01;
        if (w_sw) begin
          w_dmwr = 1'b1;
          w_done = 1'b1;
        end else if (w_lw) begin
          w_next = S_WB;
        end
      end
      S_WB: begin
        w_regwr = 1'b1;
        w_done  = 1'b1;
        if (w_rtype) w_regdst = 2'b01;
        if (w_lw)    w_wdsel  = 2'b01;
        if (w_alu_res) begin
          w_aluop  = w_aluop_x;
          w_alusrc = w_alusrc_x;
          w_extop  = w_extop_x;
        end
      end
      default: w_next = S_IF;
    endcase
    // Reset wins over any state: no writes, no done, selects at their defaults.
    if (rst) begin
      w_pcwr   = 1'b0;
      w_irwr   = 1'b0;
      w_npcop  = 2'b00;
      w_regwr  = 1'b0;
      w_regdst = 2'b00;
      w_wdsel  = 2'b00;
      w_alusrc = 1'b0;
      w_aluop  = 2'b00;
      w_extop  = 2'b00;
      w_dmwr   = 1'b0;
      w_done   = 1'b0;
    end
  end

  assign bus.pcwr   = w_pcwr;
  assign bus.irwr   = w_irwr;
  assign bus.npcop  = w_npcop;
  assign bus.regwr  = w_regwr;
  assign bus.regdst = w_regdst;
  assign bus.wdsel  = w_wdsel;
  assign bus.alusrc = w_alusrc;
  assign bus.aluop  = w_aluop;
  assign bus.extop  = w_extop;
  assign bus.dmwr   = w_dmwr;
  assign bus.done   = w_done;
  assign bus.state  = r_state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: each task drives one scenario and checks inline.
module tb_mc_ctrl;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  mc_ctrl_if bus ();

  mc_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.op = 6'b101011;
    bus.funct = 6'b000000;
    bus.zero = 1'b0;
    tick();
    n_tests++;
    if (bus.state !== 3'd0 || bus.pcwr !== 1'b0 || bus.irwr !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init: state=%0d pcwr=%b irwr=%b done=%b expected 0 0 0 0",
               bus.state, bus.pcwr, bus.irwr, bus.done);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (bus.irwr !== 1'b1 || bus.pcwr !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_if: irwr=%b pcwr=%b expected 1 1", bus.irwr, bus.pcwr);
    end
    tick(); tick(); tick();
    n_tests++;
    if (bus.state !== 3'd3 || bus.dmwr !== 1'b1 || bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_mem: state=%0d dmwr=%b done=%b expected 3 1 1",
               bus.state, bus.dmwr, bus.done);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.dmwr !== 1'b0 || bus.done !== 1'b0 || bus.state !== 3'd3) begin
      n_fail++;
      $display("FAIL reset_mem_gate: dmwr=%b done=%b state=%0d expected 0 0 3",
               bus.dmwr, bus.done, bus.state);
    end
    tick();
    n_tests++;
    if (bus.state !== 3'd0 || bus.dmwr !== 1'b0 || bus.irwr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_edge1: state=%0d dmwr=%b irwr=%b expected 0 0 0",
               bus.state, bus.dmwr, bus.irwr);
    end
    tick();
    n_tests++;
    if (bus.state !== 3'd0 || bus.dmwr !== 1'b0 || bus.pcwr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_edge2: state=%0d dmwr=%b pcwr=%b expected 0 0 0",
               bus.state, bus.dmwr, bus.pcwr);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (bus.state !== 3'd0 || bus.irwr !== 1'b1 || bus.pcwr !== 1'b1 || bus.npcop !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_release: state=%0d irwr=%b pcwr=%b npcop=%b expected 0 1 1 00",
               bus.state, bus.irwr, bus.pcwr, bus.npcop);
    end
  endtask

  task automatic test_sequence();
    logic [5:0] ops [5];
    logic [5:0] fns [5];
    int lens [5];
    int traces [5][5];
    int done_exp [5];
    int done_cyc [5];
    int cyc;
    int di;
    ops      = '{6'b001101, 6'b000000, 6'b100011, 6'b101011, 6'b001111};
    fns      = '{6'b000000, 6'b100001, 6'b000000, 6'b000000, 6'b000000};
    lens     = '{4, 4, 5, 4, 4};
    traces   = '{'{0,1,2,4,0}, '{0,1,2,4,0}, '{0,1,2,3,4}, '{0,1,2,3,0}, '{0,1,2,4,0}};
    done_exp = '{4, 8, 13, 17, 21};
    done_cyc = '{0, 0, 0, 0, 0};
    cyc = 0;
    di  = 0;
    for (int i = 0; i < 5; i++) begin
      bus.op = ops[i];
      bus.funct = fns[i];
      for (int k = 0; k < lens[i]; k++) begin
        cyc++;
        #1;
        n_tests++;
        if (bus.state !== 3'(traces[i][k])) begin
          n_fail++;
          $display("FAIL seq_state[%0d.%0d]: got %0d expected %0d", i, k, bus.state, traces[i][k]);
        end
        n_tests++;
        if (bus.done !== (k == lens[i] - 1)) begin
          n_fail++;
          $display("FAIL seq_done[%0d.%0d]: got %b expected %b", i, k, bus.done, (k == lens[i] - 1));
        end
        if (bus.done === 1'b1) begin
          if (di < 5) done_cyc[di] = cyc;
          di++;
        end
        if (i == 0 && k == 2) begin
          n_tests++;
          if (bus.aluop !== 2'b10 || bus.alusrc !== 1'b1 || bus.extop !== 2'b00) begin
            n_fail++;
            $display("FAIL ori_exe: aluop=%b alusrc=%b extop=%b expected 10 1 00",
                     bus.aluop, bus.alusrc, bus.extop);
          end
        end
        if (i == 1 && k == 3) begin
          n_tests++;
          if (bus.regwr !== 1'b1 || bus.regdst !== 2'b01 || bus.wdsel !== 2'b00) begin
            n_fail++;
            $display("FAIL addu_wb: regwr=%b regdst=%b wdsel=%b expected 1 01 00",
                     bus.regwr, bus.regdst, bus.wdsel);
          end
        end
        if (i == 2 && k == 4) begin
          n_tests++;
          if (bus.regwr !== 1'b1 || bus.regdst !== 2'b00 || bus.wdsel !== 2'b01) begin
            n_fail++;
            $display("FAIL lw_wb: regwr=%b regdst=%b wdsel=%b expected 1 00 01",
                     bus.regwr, bus.regdst, bus.wdsel);
          end
        end
        if (i == 4 && k == 2) begin
          n_tests++;
          if (bus.extop !== 2'b10 || bus.alusrc !== 1'b1 || bus.aluop !== 2'b10) begin
            n_fail++;
            $display("FAIL lui_exe: extop=%b alusrc=%b aluop=%b expected 10 1 10",
                     bus.extop, bus.alusrc, bus.aluop);
          end
        end
        @(posedge clk);
      end
    end
    #1;
    n_tests++;
    if (di != 5) begin
      n_fail++;
      $display("FAIL seq_done_count: got %0d expected 5", di);
    end
    for (int d = 0; d < 5; d++) begin
      n_tests++;
      if (done_cyc[d] != done_exp[d]) begin
        n_fail++;
        $display("FAIL seq_done_cycle[%0d]: got %0d expected %0d", d, done_cyc[d], done_exp[d]);
      end
    end
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      bus.op = 6'b000100;
      bus.funct = 6'b000000;
      bus.zero = z[0];
      n_tests++;
      if (bus.state !== 3'd0) begin
        n_fail++;
        $display("FAIL beq_start[z=%0d]: state=%0d expected 0", z, bus.state);
      end
      tick();
      n_tests++;
      if (bus.state !== 3'd1 || bus.pcwr !== 1'b0 || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL beq_id[z=%0d]: state=%0d pcwr=%b done=%b expected 1 0 0",
                 z, bus.state, bus.pcwr, bus.done);
      end
      tick();
      n_tests++;
      if (bus.state !== 3'd5 || bus.pcwr !== z[0] || bus.npcop !== 2'b01 ||
          bus.aluop !== 2'b01 || bus.extop !== 2'b01 || bus.done !== 1'b1) begin
        n_fail++;
        $display("FAIL beq_br[z=%0d]: state=%0d pcwr=%b npcop=%b aluop=%b extop=%b done=%b expected 5 %b 01 01 01 1",
                 z, bus.state, bus.pcwr, bus.npcop, bus.aluop, bus.extop, bus.done, z[0]);
      end
      tick();
      n_tests++;
      if (bus.state !== 3'd0) begin
        n_fail++;
        $display("FAIL beq_end[z=%0d]: state=%0d expected 0", z, bus.state);
      end
    end
    bus.zero = 1'b0;
  endtask

  task automatic test_jal();
    bus.op = 6'b000011;
    bus.funct = 6'b000000;
    tick();
    n_tests++;
    if (bus.state !== 3'd1 || bus.pcwr !== 1'b1 || bus.npcop !== 2'b10 || bus.regwr !== 1'b1 ||
        bus.regdst !== 2'b10 || bus.wdsel !== 2'b10 || bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL jal_id: state=%0d pcwr=%b npcop=%b regwr=%b regdst=%b wdsel=%b done=%b expected 1 1 10 1 10 10 1",
               bus.state, bus.pcwr, bus.npcop, bus.regwr, bus.regdst, bus.wdsel, bus.done);
    end
    tick();
    n_tests++;
    if (bus.state !== 3'd0) begin
      n_fail++;
      $display("FAIL jal_end: state=%0d expected 0", bus.state);
    end
  endtask

  task automatic test_jr();
    bus.op = 6'b000000;
    bus.funct = 6'b001000;
    n_tests++;
    if (bus.regwr !== 1'b0) begin
      n_fail++;
      $display("FAIL jr_if_regwr: got %b expected 0", bus.regwr);
    end
    tick();
    n_tests++;
    if (bus.state !== 3'd1 || bus.pcwr !== 1'b1 || bus.npcop !== 2'b11 ||
        bus.regwr !== 1'b0 || bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL jr_id: state=%0d pcwr=%b npcop=%b regwr=%b done=%b expected 1 1 11 0 1",
               bus.state, bus.pcwr, bus.npcop, bus.regwr, bus.done);
    end
    tick();
    n_tests++;
    if (bus.state !== 3'd0 || bus.regwr !== 1'b0) begin
      n_fail++;
      $display("FAIL jr_end: state=%0d regwr=%b expected 0 0", bus.state, bus.regwr);
    end
  endtask

  task automatic test_unknown();
    logic [5:0] uops [2];
    logic [5:0] ufns [2];
    uops = '{6'b111111, 6'b000000};
    ufns = '{6'b000000, 6'b000000};
    for (int u = 0; u < 2; u++) begin
      bus.op = uops[u];
      bus.funct = ufns[u];
      tick();
      n_tests++;
      if (bus.state !== 3'd1 || bus.pcwr !== 1'b0 || bus.regwr !== 1'b0 ||
          bus.dmwr !== 1'b0 || bus.done !== 1'b1) begin
        n_fail++;
        $display("FAIL nop_id[%0d]: state=%0d pcwr=%b regwr=%b dmwr=%b done=%b expected 1 0 0 0 1",
                 u, bus.state, bus.pcwr, bus.regwr, bus.dmwr, bus.done);
      end
      tick();
      n_tests++;
      if (bus.state !== 3'd0 || bus.regwr !== 1'b0 || bus.dmwr !== 1'b0) begin
        n_fail++;
        $display("FAIL nop_end[%0d]: state=%0d regwr=%b dmwr=%b expected 0 0 0",
                 u, bus.state, bus.regwr, bus.dmwr);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.op = 6'b000000;
    bus.funct = 6'b000000;
    bus.zero = 1'b0;
    test_reset();
    test_sequence();
    test_beq();
    test_jal();
    test_jr();
    test_unknown();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
